// File: rtl/hpdc_resp_model_if.sv
// HPDC request/response types and the core-side handshake bundle used by the
// scratchpad-backed data-cache responder.
package hpdc_pkg;

  localparam int unsigned TID_W = 8;
  localparam int unsigned SID_W = 3;

  typedef enum logic [3:0] {
    OP_LOAD,
    OP_STORE,
    OP_LR,
    OP_SC,
    OP_AMO_SWAP,
    OP_AMO_ADD,
    OP_AMO_AND,
    OP_AMO_OR,
    OP_AMO_XOR,
    OP_AMO_MAX,
    OP_AMO_MAXU,
    OP_AMO_MIN,
    OP_AMO_MINU
  } hpdcache_op_t;

  typedef struct packed {
    hpdcache_op_t     op;
    logic [63:0]      addr;
    logic [7:0]       be;
    logic [0:0][63:0] wdata;
    logic [2:0]       size;
    logic [SID_W-1:0] sid;
    logic [TID_W-1:0] tid;
    logic             need_rsp;
    logic             uncacheable;
  } hpdcache_req_t;

  typedef struct packed {
    logic [0:0][63:0] rdata;
    logic [SID_W-1:0] sid;
    logic [TID_W-1:0] tid;
    logic             error;
    logic             aborted;
  } hpdcache_rsp_t;

  typedef struct packed {
    logic             valid;
    logic [TID_W-1:0] tid;
    logic [SID_W-1:0] sid;
    logic [63:0]      rdata;
    logic             error;
  } pipe_stage_t;

endpackage

interface hpdc_resp_model_if
  import hpdc_pkg::*;
();
  logic          core_req_valid_i;
  hpdcache_req_t req_dcache_i;
  logic          dcache_ready_o;
  logic          dcache_valid_o;
  hpdcache_rsp_t rsp_dcache_o;

  modport master (
    output core_req_valid_i, req_dcache_i,
    input  dcache_ready_o, dcache_valid_o, rsp_dcache_o
  );

  modport slave (
    input  core_req_valid_i, req_dcache_i,
    output dcache_ready_o, dcache_valid_o, rsp_dcache_o
  );
endinterface

// File: rtl/hpdc_resp_model.sv
// Stand-in data cache: executes loads, stores, LR/SC and AMOs against a local
// 64-bit scratchpad in the accept cycle and replies in order after LATENCY cycles.
module hpdc_resp_model
  import hpdc_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned WBUF_DRAIN = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  hpdc_resp_model_if.slave bus,
  output logic             wbuf_empty_o
);

  localparam int unsigned IDX_W      = $clog2(MEM_WORDS);
  localparam logic [3:0]  DRAIN_INIT = 4'(WBUF_DRAIN);

  typedef logic [IDX_W-1:0] idx_t;

  function automatic logic [63:0] merge_bytes(logic [63:0] old_w, logic [63:0] new_w,
                                              logic [7:0] be);
    logic [63:0] res;
    res = old_w;
    for (int b = 0; b < 8; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  logic [63:0]   mem_q [MEM_WORDS];
  hpdcache_req_t req;
  logic          ready;
  logic          accept;
  idx_t          idx;
  logic          in_range;
  logic [63:0]   old_word;

  logic          resv_valid_q, resv_valid_d;
  idx_t          resv_idx_q, resv_idx_d;
  logic          resv_hit;
  logic [3:0]    drain_q, drain_d;
  pipe_stage_t   pipe_q [LATENCY];
  pipe_stage_t   stage_d;

  logic          mem_we;
  logic [63:0]   wr_word;
  logic [63:0]   rsp_rdata;
  logic          rsp_err;

  logic          amo_w;
  logic [63:0]   old_op, src_op, amo_res, amo_new;
  hpdcache_rsp_t rsp;

  assign req      = bus.req_dcache_i;
  assign ready    = ~stall_i & ~rst_i;
  assign accept   = bus.core_req_valid_i & ready;
  assign idx      = req.addr[3 +: IDX_W];
  assign in_range = (req.addr[63:3+IDX_W] == '0);
  assign old_word = mem_q[idx];
  assign resv_hit = resv_valid_q && (resv_idx_q == idx);
  assign amo_w    = (req.size == 3'd2);

  assign bus.dcache_ready_o = ready;

  // Word AMOs work on the addressed 32-bit lane, sign-extended so that one
  // 64-bit datapath serves both widths (unsigned order survives sign extension).
  always_comb begin
    old_op  = old_word;
    src_op  = req.wdata[0];
    amo_res = src_op;
    if (amo_w) begin
      old_op = req.addr[2] ? {{32{old_word[63]}}, old_word[63:32]}
                           : {{32{old_word[31]}}, old_word[31:0]};
      src_op = req.addr[2] ? {{32{req.wdata[0][63]}}, req.wdata[0][63:32]}
                           : {{32{req.wdata[0][31]}}, req.wdata[0][31:0]};
    end
    case (req.op)
      OP_AMO_SWAP: amo_res = src_op;
      OP_AMO_ADD:  amo_res = old_op + src_op;
      OP_AMO_AND:  amo_res = old_op & src_op;
      OP_AMO_OR:   amo_res = old_op | src_op;
      OP_AMO_XOR:  amo_res = old_op ^ src_op;
      OP_AMO_MAX:  amo_res = ($signed(old_op) > $signed(src_op)) ? old_op : src_op;
      OP_AMO_MAXU: amo_res = (old_op > src_op) ? old_op : src_op;
      OP_AMO_MIN:  amo_res = ($signed(old_op) < $signed(src_op)) ? old_op : src_op;
      OP_AMO_MINU: amo_res = (old_op < src_op) ? old_op : src_op;
      default:     amo_res = src_op;
    endcase
    amo_new = amo_w ? {2{amo_res[31:0]}} : amo_res;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    mem_we       = 1'b0;
    wr_word      = merge_bytes(old_word, req.wdata[0], req.be);
    rsp_rdata    = '0;
    rsp_err      = 1'b0;
    resv_valid_d = resv_valid_q;
    resv_idx_d   = resv_idx_q;
    if (accept) begin
      if (!in_range) begin
        rsp_err = 1'b1;
        if (req.op == OP_SC) resv_valid_d = 1'b0;
      end else begin
        case (req.op)
          OP_LOAD: rsp_rdata = old_word;
          OP_STORE: begin
            mem_we = 1'b1;
            if (resv_hit) resv_valid_d = 1'b0;
          end
          OP_LR: begin
            rsp_rdata    = old_word;
            resv_valid_d = 1'b1;
            resv_idx_d   = idx;
          end
          OP_SC: begin
            resv_valid_d = 1'b0;
            if (resv_hit) mem_we = 1'b1;
            else          rsp_rdata = 64'd1;
          end
          OP_AMO_SWAP, OP_AMO_ADD, OP_AMO_AND, OP_AMO_OR, OP_AMO_XOR,
          OP_AMO_MAX, OP_AMO_MAXU, OP_AMO_MIN, OP_AMO_MINU: begin
            mem_we    = 1'b1;
            wr_word   = merge_bytes(old_word, amo_new, req.be);
            rsp_rdata = old_word;
            if (resv_hit) resv_valid_d = 1'b0;
          end
          default: rsp_rdata = '0;
        endcase
      end
    end
  end

  always_comb begin
    drain_d = (drain_q == 4'd0) ? 4'd0 : drain_q - 4'd1;
    if (mem_we) drain_d = DRAIN_INIT;

    stage_d = '0;
    if (accept) begin
      stage_d.valid = req.need_rsp;
      stage_d.tid   = req.tid;
      stage_d.sid   = req.sid;
      stage_d.rdata = rsp_rdata;
      stage_d.error = rsp_err;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values and the pipeline shift order does not matter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resv_valid_q <= 1'b0;
      resv_idx_q   <= '0;
      drain_q      <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      resv_valid_q <= resv_valid_d;
      resv_idx_q   <= resv_idx_d;
      drain_q      <= drain_d;
      pipe_q[0]    <= stage_d;
      for (int unsigned i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // NOTE: the scratchpad has no reset; clearing it would need a per-word sweep
  // and writes made before a reset must survive it.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[idx] <= wr_word;
  end

  always_comb begin
    rsp          = '0;
    rsp.rdata[0] = pipe_q[LATENCY-1].rdata;
    rsp.sid      = pipe_q[LATENCY-1].sid;
    rsp.tid      = pipe_q[LATENCY-1].tid;
    rsp.error    = pipe_q[LATENCY-1].error;
  end

  assign bus.dcache_valid_o = pipe_q[LATENCY-1].valid;
  assign bus.rsp_dcache_o   = rsp;
  assign wbuf_empty_o       = (drain_q == 4'd0);

  logic unused_req;
  assign unused_req = ^{req.addr[1:0], req.uncacheable};

endmodule

// File: tb/tb_hpdc_resp_model.sv
// Randomised scoreboard bench for hpdc_resp_model against a word-level
// reference model of the scratchpad, reservation and write-buffer timing.
module tb_hpdc_resp_model;
  import hpdc_pkg::*;

  localparam int unsigned MEM_WORDS  = 1024;
  localparam int unsigned LATENCY    = 2;
  localparam int unsigned WBUF_DRAIN = 4;
  localparam int          IDX_W      = $clog2(MEM_WORDS);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0;
  logic wbuf_empty;

  hpdc_resp_model_if bus();

  hpdc_resp_model #(
    .MEM_WORDS (MEM_WORDS),
    .LATENCY   (LATENCY),
    .WBUF_DRAIN(WBUF_DRAIN)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .stall_i     (stall),
    .bus         (bus),
    .wbuf_empty_o(wbuf_empty)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int               cyc;
    logic [TID_W-1:0] tid;
    logic [SID_W-1:0] sid;
    logic [63:0]      rdata;
    logic             err;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] ref_mem [int];
  bit          resv_v = 1'b0;
  int          resv_idx = 0;
  int          last_wr = -100;
  int          prev_wr = -100;
  bit          chk_wbuf = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] merge(logic [63:0] o, logic [63:0] d, logic [7:0] be);
    logic [63:0] r;
    r = o;
    for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [63:0] amo_calc(hpdcache_op_t op, logic [63:0] a, logic [63:0] b, bit w);
    int                sa, sb;
    int unsigned       ua, ub;
    longint            la, lb;
    longint unsigned   qa, qb;
    logic [31:0]       r32;
    logic [63:0]       r64;
    sa = a[31:0]; sb = b[31:0]; ua = a[31:0]; ub = b[31:0];
    la = a; lb = b; qa = a; qb = b;
    r32 = b[31:0];
    r64 = b;
    case (op)
      OP_AMO_ADD:  begin r32 = a[31:0] + b[31:0]; r64 = a + b; end
      OP_AMO_AND:  begin r32 = a[31:0] & b[31:0]; r64 = a & b; end
      OP_AMO_OR:   begin r32 = a[31:0] | b[31:0]; r64 = a | b; end
      OP_AMO_XOR:  begin r32 = a[31:0] ^ b[31:0]; r64 = a ^ b; end
      OP_AMO_MAX:  begin r32 = (sa > sb) ? a[31:0] : b[31:0]; r64 = (la > lb) ? a : b; end
      OP_AMO_MAXU: begin r32 = (ua > ub) ? a[31:0] : b[31:0]; r64 = (qa > qb) ? a : b; end
      OP_AMO_MIN:  begin r32 = (sa < sb) ? a[31:0] : b[31:0]; r64 = (la < lb) ? a : b; end
      OP_AMO_MINU: begin r32 = (ua < ub) ? a[31:0] : b[31:0]; r64 = (qa < qb) ? a : b; end
      default:     begin r32 = b[31:0]; r64 = b; end
    endcase
    return w ? {32'b0, r32} : r64;
  endfunction

  // Reference: applies one accepted request to the model state.
  function automatic void model(input hpdcache_op_t op, input logic [63:0] addr,
                                input logic [7:0] be, input logic [63:0] wd,
                                input logic [2:0] size,
                                output logic [63:0] rd, output logic err);
    int          idx;
    bit          wr;
    logic [63:0] old, nw, lane_w, r;
    idx = int'(addr[3 +: IDX_W]);
    wr  = 1'b0;
    nw  = '0;
    rd  = '0;
    err = 1'b0;
    if ((addr >> (3 + IDX_W)) != 0) begin
      err = 1'b1;
      if (op == OP_SC) resv_v = 1'b0;
      return;
    end
    old = ref_mem[idx];
    case (op)
      OP_LOAD:  rd = old;
      OP_STORE: begin nw = merge(old, wd, be); wr = 1'b1; end
      OP_LR:    begin rd = old; resv_v = 1'b1; resv_idx = idx; end
      OP_SC: begin
        if (resv_v && resv_idx == idx) begin nw = merge(old, wd, be); wr = 1'b1; end
        else rd = 64'd1;
        resv_v = 1'b0;
      end
      default: begin
        rd = old;
        if (size == 3'd2) begin
          r = addr[2] ? amo_calc(op, {32'b0, old[63:32]}, {32'b0, wd[63:32]}, 1'b1)
                      : amo_calc(op, {32'b0, old[31:0]},  {32'b0, wd[31:0]},  1'b1);
          lane_w = addr[2] ? {r[31:0], old[31:0]} : {old[63:32], r[31:0]};
          nw = merge(old, lane_w, be);
        end else begin
          nw = merge(old, amo_calc(op, old, wd, 1'b0), be);
        end
        wr = 1'b1;
      end
    endcase
    if (wr) begin
      ref_mem[idx] = nw;
      if (resv_idx == idx) resv_v = 1'b0;
      prev_wr = last_wr;
      last_wr = cyc;
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called 1 time unit after a rising edge; the request is offered for one cycle.
  task automatic issue(input hpdcache_op_t op, input logic [63:0] addr,
                       input logic [7:0] be, input logic [63:0] wd,
                       input logic [2:0] size = 3'd3, input bit need = 1'b1,
                       input bit stall_now = 1'b0, input int tid_in = -1);
    hpdcache_req_t r;
    logic [63:0]   rd;
    logic          err;
    exp_t          e;
    r             = '0;
    r.op          = op;
    r.addr        = addr;
    r.be          = be;
    r.wdata[0]    = wd;
    r.size        = size;
    r.sid         = 3'($urandom);
    r.tid         = (tid_in < 0) ? 8'($urandom) : 8'(tid_in);
    r.need_rsp    = need;
    r.uncacheable = 1'($urandom);
    bus.req_dcache_i     = r;
    bus.core_req_valid_i = 1'b1;
    stall                = stall_now;
    if (stall_now) begin
      #1;
      check("ready_under_stall", bus.dcache_ready_o, 0);
    end else begin
      model(op, addr, be, wd, size, rd, err);
      if (need) begin
        e.cyc   = cyc + LATENCY;
        e.tid   = r.tid;
        e.sid   = r.sid;
        e.rdata = rd;
        e.err   = err;
        sb_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    bus.core_req_valid_i = 1'b0;
    stall                = 1'b0;
  endtask

  exp_t mon_e;
  int   eff_wr;

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      n_vec++;
      n_err++;
      $display("FAIL rsp_missing: no response seen for tid 0x%0h due cycle %0d, required one (now %0d)",
               sb_q[0].tid, sb_q[0].cyc, cyc);
      void'(sb_q.pop_front());
    end
    if (bus.dcache_valid_o === 1'b1) begin
      if (sb_q.size() == 0 || sb_q[0].cyc != cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL rsp_unexpected: got valid with tid 0x%0h at cycle %0d, required no response",
                 bus.rsp_dcache_o.tid, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("rsp_tid",     bus.rsp_dcache_o.tid,      mon_e.tid);
        check("rsp_sid",     bus.rsp_dcache_o.sid,      mon_e.sid);
        check("rsp_rdata",   bus.rsp_dcache_o.rdata[0], mon_e.rdata);
        check("rsp_error",   bus.rsp_dcache_o.error,    mon_e.err);
        check("rsp_aborted", bus.rsp_dcache_o.aborted,  0);
      end
    end
    if (chk_wbuf) begin
      eff_wr = (last_wr < cyc) ? last_wr : prev_wr;
      check("wbuf_empty", wbuf_empty, ((cyc - eff_wr) > int'(WBUF_DRAIN)) ? 1 : 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    hpdcache_op_t op;
    logic [63:0]  addr;
    logic [7:0]   be;
    logic [2:0]   size;
    int           idx;
    bit           hi;

    bus.core_req_valid_i = 1'b0;
    bus.req_dcache_i     = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", bus.dcache_valid_o, 0);
    check("reset_ready", bus.dcache_ready_o, 0);
    check("reset_wbuf",  wbuf_empty, 1);
    check("reset_rsp",   bus.rsp_dcache_o, 0);
    rst      = 1'b0;
    chk_wbuf = 1'b1;

    for (int i = 0; i < 32; i++) issue(OP_STORE, 64'(i * 8), 8'hFF, {$urandom, $urandom});
    idle(6);

    // Store/load round trip, then a byte-lane merge.
    issue(OP_STORE, 64'h40, 8'hFF, 64'h1122334455667788, 3'd3, 1'b1, 1'b0, 5);
    issue(OP_LOAD,  64'h40, 8'hFF, 64'h0,                3'd3, 1'b1, 1'b0, 6);
    issue(OP_STORE, 64'h41, 8'h02, 64'hAB00, 3'd0);
    issue(OP_LOAD,  64'h40, 8'hFF, 64'h0);

    // LR/SC success, then SC without a reservation.
    issue(OP_LR,   64'h80, 8'hFF, 64'h0);
    issue(OP_SC,   64'h80, 8'hFF, 64'd7);
    issue(OP_LOAD, 64'h80, 8'hFF, 64'h0);
    issue(OP_SC,   64'h80, 8'hFF, 64'd9);
    issue(OP_LOAD, 64'h80, 8'hFF, 64'h0);

    // Word AMO_ADD on the upper lane wraps to zero.
    issue(OP_STORE,   64'h48, 8'hFF, 64'hFFFFFFFF_00000001);
    issue(OP_AMO_ADD, 64'h4C, 8'hF0, 64'h00000001_00000000, 3'd2);
    issue(OP_LOAD,    64'h48, 8'hFF, 64'h0);
    idle(6);

    // Stall for three cycles, then a silent store and its drain window.
    repeat (3) issue(OP_LOAD, 64'h0, 8'hFF, 64'h0, 3'd3, 1'b1, 1'b1);
    issue(OP_STORE, 64'h50, 8'hFF, 64'hCAFEF00D_12345678, 3'd3, 1'b0);
    idle(8);
    issue(OP_LOAD, 64'h50, 8'hFF, 64'h0);
    idle(4);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) idle(1);
      idx  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 3);
      addr = 64'(idx * 8);
      if ($urandom_range(0, 19) == 0) addr = addr | (64'd1 << (3 + IDX_W + $urandom_range(0, 20)));
      op   = hpdcache_op_t'($urandom_range(0, 12));
      be   = 8'hFF;
      size = 3'd3;
      if (op == OP_STORE || op == OP_SC) be = 8'($urandom);
      if (op >= OP_AMO_SWAP && $urandom_range(0, 1) == 1) begin
        hi   = 1'($urandom);
        addr = addr | (hi ? 64'd4 : 64'd0);
        be   = hi ? 8'hF0 : 8'h0F;
        size = 3'd2;
      end
      issue(op, addr, be, {$urandom, $urandom}, size,
            $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0);
    end
    idle(6);

    // Reset with loads in flight: only a response already at the output survives.
    issue(OP_LOAD, 64'h10, 8'hFF, 64'h0);
    issue(OP_LOAD, 64'h18, 8'hFF, 64'h0);
    rst      = 1'b1;
    chk_wbuf = 1'b0;
    resv_v   = 1'b0;
    while (sb_q.size() > 0 && sb_q[$].cyc > cyc) void'(sb_q.pop_back());
    #1;
    check("ready_in_reset", bus.dcache_ready_o, 0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    last_wr  = -100;
    prev_wr  = -100;
    chk_wbuf = 1'b1;
    check("rsp_after_reset", bus.rsp_dcache_o, 0);
    idle(4);

    issue(OP_LOAD, 64'(MEM_WORDS) * 64'd8, 8'hFF, 64'h0);
    issue(OP_LOAD, 64'h40, 8'hFF, 64'h0);
    idle(LATENCY + 3);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
